conv_window_seq: RTL and testbench

Parametrised convolution sequencer: slides a K×K binary-mask window over a single-channel image held in synchronous RAM, reduces each window to one pixel, and writes the results back to the same RAM. It is the next-generation controller for the convolution datapath. It adds the following over the previous fixed-function controller:
- configurable stride;
- selectable reduction mode (saturating sum, shifted sum, max);
- a clean start/busy/done handshake;
- fully synchronous single-clock timing with no delay-based sequencing.

---
 rtl/conv_window_seq.sv | 182 ++++++++++++++++++
 tb/tb_conv_window_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_seq.sv
// Convolution window sequencer: walks a KxK masked window over an image in RAM and writes one reduced pixel per window.
// Optional macro CONV_SEQ_ROUND_EN: mode 01 rounds to nearest instead of truncating.
module conv_window_seq #(
   parameter int K          = 3,
   parameter int IMG_W      = 220,
   parameter int IMG_H      = 220,
   parameter int STRIDE     = 1,
   parameter int DW         = 8,
   parameter int AW         = 16,
   parameter int IMG_BASE   = 0,
   parameter int RES_BASE   = 49152,
   parameter int NORM_SHIFT = 3
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [1:0]      mode,
   input  logic [K*K-1:0]  kernel,
   output logic            busy,
   output logic            done,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata
);
   // state   | meaning
   // S_IDLE  | waiting for start
   // S_FETCH | one window read per cycle, ky outer / kx inner
   // S_DRAIN | absorbs the data of the last read
   // S_WRITE | writes the reduced pixel, advances to the next window
   // S_DONE  | one-cycle done pulse

   localparam int OW  = (IMG_W - K) / STRIDE + 1;
   localparam int OH  = (IMG_H - K) / STRIDE + 1;
   localparam int NK  = K * K;
   localparam int IW  = $clog2(NK);
   localparam int KW  = $clog2(K);
   localparam int XW  = $clog2(OW + 1);
   localparam int YW  = $clog2(OH + 1);
   localparam int ACW = DW + $clog2(NK);
   localparam logic [ACW:0] MAXV = {{(ACW + 1 - DW){1'b0}}, {DW{1'b1}}};

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;
   state_t state_q, state_d;

   logic [K*K-1:0] kernel_q;
   logic [1:0]     mode_q;
   logic [IW-1:0]  idx, rd_idx;
   logic [KW-1:0]  kx;
   logic [XW-1:0]  ox;
   logic [YW-1:0]  oy;
   logic [AW-1:0]  line_base, win_base, rd_row, wr_addr;
   logic [ACW-1:0] acc, pix_ext;
   logic           rd_pend;
   logic           last_win;
   logic [ACW:0]   shifted, scaled;
   logic [DW-1:0]  result;

   assign last_win = (ox == XW'(OW - 1)) && (oy == YW'(OH - 1));
   assign pix_ext  = ACW'(mem_rdata);

`ifdef CONV_SEQ_ROUND_EN
   localparam int RND_I = (NORM_SHIFT > 0) ? 2 ** (NORM_SHIFT - 1) : 0;
   assign shifted = ({1'b0, acc} + (ACW + 1)'(RND_I)) >> NORM_SHIFT;
`else
   assign shifted = {1'b0, acc} >> NORM_SHIFT;
`endif

   always_comb begin
      scaled = {1'b0, acc};
      if (mode_q == 2'b01) scaled = shifted;
      result = (scaled > MAXV) ? {DW{1'b1}} : scaled[DW-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: begin
            busy     = 1'b1;
            mem_en   = 1'b1;
            mem_addr = rd_row + AW'(kx);
            if (idx == IW'(NK - 1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy    = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            busy      = 1'b1;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = result;
            state_d   = last_win ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         kernel_q  <= '0;
         mode_q    <= '0;
         idx       <= '0;
         rd_idx    <= '0;
         kx        <= '0;
         ox        <= '0;
         oy        <= '0;
         line_base <= '0;
         win_base  <= '0;
         rd_row    <= '0;
         wr_addr   <= '0;
         acc       <= '0;
         rd_pend   <= 1'b0;
      end else begin
         // read data returns one cycle after the address, so the mask bit is delayed with it
         rd_pend <= (state_q == S_FETCH);
         rd_idx  <= idx;
         if (rd_pend && kernel_q[rd_idx]) begin
            if (mode_q == 2'b10) acc <= (pix_ext > acc) ? pix_ext : acc;
            else                 acc <= acc + pix_ext;
         end
         unique case (state_q)
            S_IDLE: if (start) begin
               kernel_q  <= kernel;
               mode_q    <= mode;
               acc       <= '0;
               idx       <= '0;
               kx        <= '0;
               ox        <= '0;
               oy        <= '0;
               line_base <= AW'(IMG_BASE);
               win_base  <= AW'(IMG_BASE);
               rd_row    <= AW'(IMG_BASE);
               wr_addr   <= AW'(RES_BASE);
            end
            S_FETCH: begin
               idx <= (idx == IW'(NK - 1)) ? '0 : idx + 1'b1;
               if (kx == KW'(K - 1)) begin
                  kx     <= '0;
                  rd_row <= rd_row + AW'(IMG_W);
               end else begin
                  kx <= kx + 1'b1;
               end
            end
            S_WRITE: begin
               acc     <= '0;
               wr_addr <= wr_addr + 1'b1;
               if (ox == XW'(OW - 1)) begin
                  ox        <= '0;
                  oy        <= oy + 1'b1;
                  line_base <= line_base + AW'(STRIDE * IMG_W);
                  win_base  <= line_base + AW'(STRIDE * IMG_W);
                  rd_row    <= line_base + AW'(STRIDE * IMG_W);
               end else begin
                  ox       <= ox + 1'b1;
                  win_base <= win_base + AW'(STRIDE);
                  rd_row   <= win_base + AW'(STRIDE);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_window_seq.sv
// Bench for conv_window_seq: 5x5 image, stride-1 and stride-2 instances sharing one image RAM.
module tb_conv_window_seq;
   localparam int RES_BASE = 49152;
`ifdef CONV_SEQ_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        start1, start2;
   logic [1:0]  mode_i;
   logic [8:0]  kern_i;
   logic        busy1, done1, en1, we1, busy2, done2, en2, we2;
   logic [15:0] addr1, addr2;
   logic [7:0]  wd1, wd2, rd1, rd2;

   logic [7:0]  img [0:24];
   logic [15:0] la1 [0:255];
   logic [7:0]  ld1 [0:255];
   logic [15:0] la2 [0:255];
   logic [7:0]  ld2 [0:255];
   int          wcnt1 = 0;
   int          wcnt2 = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   conv_window_seq #(.K(3), .IMG_W(5), .IMG_H(5), .STRIDE(1), .DW(8), .AW(16),
                     .IMG_BASE(0), .RES_BASE(RES_BASE), .NORM_SHIFT(3)) dut1 (
      .clk(clk), .rstn(rstn), .start(start1), .mode(mode_i), .kernel(kern_i),
      .busy(busy1), .done(done1), .mem_en(en1), .mem_we(we1), .mem_addr(addr1),
      .mem_wdata(wd1), .mem_rdata(rd1));

   conv_window_seq #(.K(3), .IMG_W(5), .IMG_H(5), .STRIDE(2), .DW(8), .AW(16),
                     .IMG_BASE(0), .RES_BASE(RES_BASE), .NORM_SHIFT(3)) dut2 (
      .clk(clk), .rstn(rstn), .start(start2), .mode(mode_i), .kernel(kern_i),
      .busy(busy2), .done(done2), .mem_en(en2), .mem_we(we2), .mem_addr(addr2),
      .mem_wdata(wd2), .mem_rdata(rd2));

   always @(posedge clk) begin
      if (en1 && !we1) rd1 <= (addr1 < 16'd25) ? img[addr1[4:0]] : 8'h00;
      if (en1 && we1) begin
         la1[wcnt1[7:0]] <= addr1;
         ld1[wcnt1[7:0]] <= wd1;
         wcnt1 <= wcnt1 + 1;
      end
      if (en2 && !we2) rd2 <= (addr2 < 16'd25) ? img[addr2[4:0]] : 8'h00;
      if (en2 && we2) begin
         la2[wcnt2[7:0]] <= addr2;
         ld2[wcnt2[7:0]] <= wd2;
         wcnt2 <= wcnt2 + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference: direct evaluation of one output window from the image.
   function automatic int ref_px(input int s, input int ox, input int oy,
                                 input logic [1:0] m, input logic [8:0] k);
      int acc = 0;
      for (int ky = 0; ky < 3; ky++)
         for (int kx = 0; kx < 3; kx++)
            if (k[ky*3+kx]) begin
               int p = int'(img[(oy*s+ky)*5 + ox*s + kx]);
               if (m == 2'd2) acc = (p > acc) ? p : acc;
               else           acc = acc + p;
            end
      if (m == 2'd1) acc = RND ? (acc + 4) / 8 : acc / 8;
      return (acc > 255) ? 255 : acc;
   endfunction

   task automatic verify(input int d, input int base, input int n, input int s, input int ow,
                         input logic [1:0] m, input logic [8:0] k, input string tag);
      for (int i = 0; i < n; i++) begin
         int a;
         int v;
         a = (d == 1) ? int'(la1[8'(base+i)]) : int'(la2[8'(base+i)]);
         v = (d == 1) ? int'(ld1[8'(base+i)]) : int'(ld2[8'(base+i)]);
         check($sformatf("%s_d%0d_addr%0d", tag, d, i), a, RES_BASE + i);
         check($sformatf("%s_d%0d_pix%0d", tag, d, i), v, ref_px(s, i % ow, i / ow, m, k));
      end
   endtask

   // Full run on both instances; poke adds a start while busy (with changed inputs) and a start in DONE.
   task automatic run_and_check(input logic [1:0] m, input logic [8:0] k, input bit poke,
                                input string tag, output int b1, output int b2);
      int n = 0;
      int t1 = -1;
      int t2 = -1;
      int bd1 = 1;
      b1 = wcnt1;
      b2 = wcnt2;
      mode_i = m; kern_i = k; start1 = 1'b1; start2 = 1'b1;
      @(posedge clk);
      while ((t1 < 0 || t2 < 0) && n < 400) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            start1 = 1'b0; start2 = 1'b0;
            check({tag, "_busy_t1"}, int'(busy1), 1);
            check({tag, "_en_t1"}, int'(en1), 1);
            check({tag, "_addr_t1"}, int'(addr1), 0);
         end
         if (poke && n == 30) begin
            start1 = 1'b1; mode_i = m ^ 2'b11; kern_i = ~k;
         end
         if (poke && n == 31) start1 = 1'b0;
         if (done2 && t2 < 0) t2 = n;
         if (done1 && t1 < 0) begin
            t1 = n;
            bd1 = int'(busy1);
            if (poke) start1 = 1'b1;
         end
      end
      @(negedge clk);
      start1 = 1'b0;
      check({tag, "_done_pulse"}, int'(done1), 0);
      @(negedge clk);
      check({tag, "_idle_after"}, int'(busy1), 0);
      check({tag, "_done_t1"}, t1, 100);
      check({tag, "_done_t2"}, t2, 45);
      check({tag, "_busy_at_done"}, bd1, 0);
      check({tag, "_wr1"}, wcnt1 - b1, 9);
      check({tag, "_wr2"}, wcnt2 - b2, 4);
      verify(1, b1, 9, 1, 3, m, k, tag);
      verify(2, b2, 4, 2, 2, m, k, tag);
   endtask

   typedef struct {
      logic [1:0] m;
      logic [8:0] k;
      bit         flat;
      int         r0;
      int         r8;
   } vec_t;
   vec_t vt[10];

   initial begin
      int b1;
      int b2;
      int wsnap;
      vt[0] = '{2'd0, 9'h1FF, 1'b0, 54, 162};
      vt[1] = '{2'd1, 9'h1FF, 1'b0, RND ? 7 : 6, 20};
      vt[2] = '{2'd2, 9'h1FF, 1'b0, 12, 24};
      vt[3] = '{2'd3, 9'h1FF, 1'b0, 54, 162};
      vt[4] = '{2'd0, 9'h1FF, 1'b1, 255, 255};
      vt[5] = '{2'd1, 9'h1FF, 1'b1, RND ? 113 : 112, RND ? 113 : 112};
      vt[6] = '{2'd2, 9'h1FF, 1'b1, 100, 100};
      vt[7] = '{2'd0, 9'h000, 1'b0, 0, 0};
      vt[8] = '{2'd1, 9'h000, 1'b1, 0, 0};
      vt[9] = '{2'd2, 9'h000, 1'b0, 0, 0};

      rstn = 1'b0; start1 = 1'b0; start2 = 1'b0; mode_i = 2'd0; kern_i = 9'h000;
      for (int i = 0; i < 25; i++) img[i] = 8'(i);
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy1), 0);
      check("rst_done", int'(done1), 0);
      check("rst_en", int'(en1), 0);
      check("rst_we", int'(we1), 0);
      check("rst_addr", int'(addr1), 0);
      check("rst_wdata", int'(wd1), 0);
      rstn = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 10; v++) begin
         for (int i = 0; i < 25; i++) img[i] = vt[v].flat ? 8'd100 : 8'(i);
         run_and_check(vt[v].m, vt[v].k, 1'b0, $sformatf("vec%0d", v), b1, b2);
         check($sformatf("vec%0d_r0", v), int'(ld1[8'(b1)]), vt[v].r0);
         check($sformatf("vec%0d_r8", v), int'(ld1[8'(b1+8)]), vt[v].r8);
      end

      for (int i = 0; i < 25; i++) img[i] = 8'(i);
      run_and_check(2'd0, 9'h010, 1'b0, "stride2", b1, b2);
      check("s2_r0", int'(ld2[8'(b2)]), 6);
      check("s2_r1", int'(ld2[8'(b2+1)]), 8);
      check("s2_r2", int'(ld2[8'(b2+2)]), 16);
      check("s2_r3", int'(ld2[8'(b2+3)]), 18);

      run_and_check(2'd0, 9'h1FF, 1'b1, "poke", b1, b2);

      // reset during FETCH of the second window
      wsnap = wcnt1;
      mode_i = 2'd0; kern_i = 9'h1FF; start1 = 1'b1; start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      repeat (13) @(negedge clk);
      check("mid_en_before", int'(en1), 1);
      #2 rstn = 1'b0;
      #1;
      check("mid_busy", int'(busy1), 0);
      check("mid_en", int'(en1), 0);
      check("mid_we", int'(we1), 0);
      check("mid_addr", int'(addr1), 0);
      check("mid_wdata", int'(wd1), 0);
      check("mid_wr_before", wcnt1 - wsnap, 1);
      repeat (5) @(negedge clk);
      check("mid_wr_during", wcnt1 - wsnap, 1);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_no_resume", int'(busy1), 0);
      check("mid_wr_after", wcnt1 - wsnap, 1);
      run_and_check(2'd0, 9'h1FF, 1'b0, "post_rst", b1, b2);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 25; i++) img[i] = 8'($urandom);
         run_and_check(2'($urandom_range(0, 3)), 9'($urandom), 1'b0, $sformatf("rnd%0d", r), b1, b2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
